// File: rtl/adc_spi_capture.sv
// Periodic SPI (mode 0) capture of a serial ADC: one frame per period tick, result held
// on sample_data and announced by a single-cycle sample_valid pulse.
module adc_spi_capture #(
  parameter int DATA_W        = 10,
  parameter int LEAD_BITS     = 2,
  parameter int CLK_DIV       = 2,
  parameter int CS_SETUP      = 2,
  parameter int SAMPLE_PERIOD = 500
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              adc_miso,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              overrun
);

  localparam int N    = LEAD_BITS + DATA_W;
  localparam int PW   = $clog2(SAMPLE_PERIOD + 1);
  localparam int SW   = $clog2(CS_SETUP + 1);
  localparam int DW   = $clog2(CLK_DIV + 1);
  localparam int BW   = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     per_cnt_q, per_cnt_d;
  logic              tick_q, tick_d;
  logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    tick_d      = 1'b0;
    setup_cnt_d = setup_cnt_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;

    if (!enable) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == PW'(SAMPLE_PERIOD - 1)) begin
      per_cnt_d = '0;
      tick_d    = 1'b1;
    end else begin
      per_cnt_d = per_cnt_q + PW'(1);
    end

    if (tick_q && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick_q) begin
          state_d     = SETUP;
          cs_n_d      = 1'b0;
          setup_cnt_d = '0;
        end
      end
      SETUP: begin
        // The edge leaving SETUP is the first sclk rise, so the first bit is taken here.
        if (setup_cnt_q == SW'(CS_SETUP - 1)) begin
          state_d   = SHIFT;
          sclk_d    = 1'b1;
          shreg_d   = {shreg_q[DATA_W-2:0], adc_miso};
          bit_cnt_d = BW'(1);
          div_d     = '0;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      SHIFT: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == BW'(N)) begin
            // Last low half-period has elapsed: close the frame.
            state_d = DONE;
            cs_n_d  = 1'b1;
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            sclk_d    = 1'b1;
            shreg_d   = {shreg_q[DATA_W-2:0], adc_miso};
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      tick_q      <= 1'b0;
      setup_cnt_q <= '0;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      tick_q      <= tick_d;
      setup_cnt_q <= setup_cnt_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: default instance plus a short-period instance for overrun.
module tb_adc_spi_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       adc_miso;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [9:0] sample_data;
  logic       sample_valid;
  logic       overrun;

  logic       enable2;
  logic       adc_cs_n2;
  logic       adc_sclk2;
  logic [9:0] sample_data2;
  logic       sample_valid2;
  logic       overrun2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_spi_capture dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_miso(adc_miso),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample_data(sample_data),
    .sample_valid(sample_valid), .overrun(overrun)
  );

  adc_spi_capture #(.SAMPLE_PERIOD(40)) dut_ovr (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .adc_miso(1'b1),
    .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2), .sample_data(sample_data2),
    .sample_valid(sample_valid2), .overrun(overrun2)
  );

  // ADC model: lead bits then data, MSB first; next bit presented after each sclk fall.
  logic [11:0] frame_word = 12'h000;
  int          idx = 0;
  always @(negedge adc_cs_n) begin
    idx = 0;
    adc_miso = frame_word[11];
  end
  always @(negedge adc_sclk) begin
    if (!adc_cs_n) begin
      idx = idx + 1;
      if (idx < 12) adc_miso = frame_word[11-idx];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rises = 0, falls = 0, valids = 0, run = 0, last_run = 0;
  int   fall_cyc = 0, first_rise_ofs = -1, idle_sclk_bad = 0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1;
  always @(negedge clk) begin
    if (!adc_cs_n && cs_prev) begin
      fall_cyc <= cyc;
      falls    <= falls + 1;
      rises    <= 0;
      run      <= 1;
    end else begin
      if (!adc_cs_n) run <= run + 1;
      if (adc_sclk && !sclk_prev) begin
        rises <= rises + 1;
        if (rises == 0) first_rise_ofs <= cyc - fall_cyc;
      end
    end
    if (adc_cs_n && !cs_prev) last_run <= run;
    if (adc_cs_n && adc_sclk) idle_sclk_bad <= idle_sclk_bad + 1;
    if (sample_valid) valids <= valids + 1;
    sclk_prev <= adc_sclk;
    cs_prev   <= adc_cs_n;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (sample_valid) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_valid2(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (sample_valid2) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_cs_fall(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!adc_cs_n) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int k, at, prev, f, v;
    reset_n = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_cs_n", int'(adc_cs_n), 1);
    chk("rst_sclk", int'(adc_sclk), 0);
    chk("rst_data", int'(sample_data), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_overrun2", int'(overrun2), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single frame: lead 2'b11, data 2A5
    frame_word = {2'b11, 10'h2A5};
    enable = 1'b1;
    k = cyc;
    wait_valid(700, ok, at);
    chk("valid_seen_2a5", int'(ok), 1);
    chk("lat_from_enable", at - k, 551);
    chk("lat_from_cs_fall", at - fall_cyc, 50);
    chk("data_2a5", int'(sample_data), 'h2A5);
    prev = at;
    @(negedge clk);
    chk("valid_one_cycle", int'(sample_valid), 0);
    @(negedge clk);
    chk("sclk_rises", rises, 12);
    chk("cs_low_len", last_run, 50);
    chk("first_rise_ofs", first_rise_ofs, 2);

    // Consecutive frames 3FF then 000
    frame_word = {2'b00, 10'h3FF};
    wait_valid(600, ok, at);
    chk("valid_seen_3ff", int'(ok), 1);
    chk("period_3ff", at - prev, 500);
    chk("data_3ff", int'(sample_data), 'h3FF);
    prev = at;
    frame_word = {2'b10, 10'h000};
    repeat (250) @(negedge clk);
    chk("hold_3ff", int'(sample_data), 'h3FF);
    wait_valid(600, ok, at);
    chk("valid_seen_000", int'(ok), 1);
    chk("period_000", at - prev, 500);
    chk("data_000", int'(sample_data), 'h000);

    // enable dropped 10 cycles into a frame
    frame_word = {2'b01, 10'h155};
    wait_cs_fall(600, ok);
    chk("cs_fall_seen", int'(ok), 1);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_valid(100, ok, at);
    chk("valid_after_disable", int'(ok), 1);
    chk("data_155", int'(sample_data), 'h155);
    @(negedge clk);
    f = falls;
    v = valids;
    repeat (1200) @(negedge clk);
    chk("no_cs_after_disable", falls, f);
    chk("no_valid_after_disable", valids, v);
    chk("overrun_main", int'(overrun), 0);

    // Reset mid-SHIFT
    frame_word = {2'b11, 10'h0F0};
    enable = 1'b1;
    wait_cs_fall(600, ok);
    chk("cs_fall_seen2", int'(ok), 1);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", int'(adc_cs_n), 1);
    chk("midrst_sclk", int'(adc_sclk), 0);
    chk("midrst_data", int'(sample_data), 0);
    chk("midrst_valid", int'(sample_valid), 0);
    chk("midrst_overrun", int'(overrun), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    f = falls;
    v = valids;
    repeat (1200) @(negedge clk);
    chk("no_valid_after_rst", valids, v);
    chk("no_cs_after_rst", falls, f);
    chk("data_after_rst", int'(sample_data), 0);

    // Short period: ticks arrive while frames are in flight
    enable2 = 1'b1;
    k = cyc;
    repeat (60) @(negedge clk);
    chk("ovr_clear_first", int'(overrun2), 0);
    wait_valid2(200, ok, at);
    chk("ovr_valid_seen", int'(ok), 1);
    chk("ovr_latency", at - k, 91);
    chk("ovr_data", int'(sample_data2), 'h3FF);
    chk("ovr_set", int'(overrun2), 1);
    prev = at;
    wait_valid2(200, ok, at);
    chk("ovr_valid_seen2", int'(ok), 1);
    chk("ovr_period", at - prev, 80);
    chk("ovr_data2", int'(sample_data2), 'h3FF);
    chk("ovr_sticky", int'(overrun2), 1);
    enable2 = 1'b0;
    repeat (60) @(negedge clk);

    chk("sclk_low_when_idle", idle_sclk_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
